// File: rtl/ex_tex_blk_fetch_pkg.sv
// Shared texture-unit definitions: fetch FSM encoding, block size default and
// the texture log-size clamp.
package ex_tex_blk_fetch_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StMiss = 2'b01,
    StOut  = 2'b10
  } fetch_state_e;

  localparam int unsigned BlkBytesLg2 = 3;

  // Blocks are 4x4 texels, so dimensions below 4 or above 4096 are not addressable.
  function automatic logic [3:0] clamp_log(input logic [3:0] lg);
    if (lg < 4'd2) return 4'd2;
    if (lg > 4'd12) return 4'd12;
    return lg;
  endfunction

endpackage

// File: rtl/ex_tex_blk_fetch_if.sv
// Request, memory and decoder-side signals of the texture block fetch stage.
interface ex_tex_blk_fetch_if #(
  parameter int unsigned ADDR_W = 48
);
  logic              reqValid;
  logic              reqReady;
  logic [15:0]       reqU;
  logic [15:0]       reqV;
  logic [8:0]        reqUIxt;
  logic [ADDR_W-1:0] texBase;
  logic [3:0]        texLogW;
  logic [3:0]        texLogH;
  logic              flush;
  logic              memReqValid;
  logic [ADDR_W-1:0] memReqAddr;
  logic              memAck;
  logic [63:0]       memData;
  logic              outValid;
  logic              outReady;
  logic [63:0]       outBlock;
  logic [3:0]        outPixIx;
  logic [8:0]        outUIxt;

  // Environment side: issues texel requests, serves memory, consumes blocks.
  modport master (
    output reqValid, reqU, reqV, reqUIxt, texBase, texLogW, texLogH, flush,
           memAck, memData, outReady,
    input  reqReady, memReqValid, memReqAddr, outValid, outBlock, outPixIx, outUIxt
  );

  // Fetch stage side.
  modport slave (
    input  reqValid, reqU, reqV, reqUIxt, texBase, texLogW, texLogH, flush,
           memAck, memData, outReady,
    output reqReady, memReqValid, memReqAddr, outValid, outBlock, outPixIx, outUIxt
  );
endinterface

// File: rtl/ex_tex_blk_addr.sv
// Combinational texel-to-block mapping: repeat wrap, block index, block address
// and pixel index inside the 4x4 block.
module ex_tex_blk_addr
  import ex_tex_blk_fetch_pkg::*;
#(
  parameter int unsigned AddrW       = 48,
  parameter int unsigned BytesLg2    = BlkBytesLg2
) (
  input  logic [15:0]      u_i,
  input  logic [15:0]      v_i,
  input  logic [AddrW-1:0] base_i,
  input  logic [3:0]       log_w_i,
  input  logic [3:0]       log_h_i,
  output logic [AddrW-1:0] addr_o,
  output logic [3:0]       pix_ix_o
);
  logic [3:0]  lw, lh;
  logic [15:0] u_w, v_w;
  logic [23:0] blk_idx;

  always_comb begin
    lw       = clamp_log(log_w_i);
    lh       = clamp_log(log_h_i);
    u_w      = u_i & ~(16'hFFFF << lw);
    v_w      = v_i & ~(16'hFFFF << lh);
    // Block rows are (width/4) blocks long.
    blk_idx  = (24'(v_w >> 2) << (lw - 4'd2)) | 24'(u_w >> 2);
    addr_o   = base_i + (AddrW'(blk_idx) << BytesLg2);
    pix_ix_o = {v_w[1:0], u_w[1:0]};
  end

endmodule

// File: rtl/ex_tex_blk_fetch.sv
// Texture block fetch stage: maps a texel to its compressed block, fetches the
// block through a one-entry cache and hands block + pixel index to the decoder.
module ex_tex_blk_fetch
  import ex_tex_blk_fetch_pkg::*;
#(
  parameter int unsigned ADDR_W        = 48,
  parameter int unsigned BLK_BYTES_LG2 = BlkBytesLg2
) (
  input  logic                clock,
  input  logic                reset,
  ex_tex_blk_fetch_if.slave   bus
);
  fetch_state_e      state_q, state_d;
  logic              tag_valid_q, tag_valid_d;
  logic [ADDR_W-1:0] tag_addr_q, tag_addr_d;
  logic [63:0]       data_q, data_d;
  logic              miss_flushed_q, miss_flushed_d;
  logic              mem_req_valid_q, mem_req_valid_d;
  logic [ADDR_W-1:0] mem_req_addr_q, mem_req_addr_d;
  logic              out_valid_q, out_valid_d;
  logic [63:0]       out_block_q, out_block_d;
  logic [3:0]        out_pix_q, out_pix_d;
  logic [8:0]        out_uixt_q, out_uixt_d;

  logic [ADDR_W-1:0] calc_addr;
  logic [3:0]        calc_pix;
  logic              accept, hit;

  ex_tex_blk_addr #(
    .AddrW    (ADDR_W),
    .BytesLg2 (BLK_BYTES_LG2)
  ) u_addr (
    .u_i      (bus.reqU),
    .v_i      (bus.reqV),
    .base_i   (bus.texBase),
    .log_w_i  (bus.texLogW),
    .log_h_i  (bus.texLogH),
    .addr_o   (calc_addr),
    .pix_ix_o (calc_pix)
  );

  assign bus.reqReady    = (state_q == StIdle) || ((state_q == StOut) && bus.outReady);
  assign bus.memReqValid = mem_req_valid_q;
  assign bus.memReqAddr  = mem_req_addr_q;
  assign bus.outValid    = out_valid_q;
  assign bus.outBlock    = out_block_q;
  assign bus.outPixIx    = out_pix_q;
  assign bus.outUIxt     = out_uixt_q;

  assign accept = bus.reqValid && bus.reqReady;
  assign hit    = tag_valid_q && (tag_addr_q == calc_addr) && !bus.flush;

  always_comb begin
    state_d         = state_q;
    tag_valid_d     = tag_valid_q;
    tag_addr_d      = tag_addr_q;
    data_d          = data_q;
    miss_flushed_d  = miss_flushed_q;
    mem_req_valid_d = mem_req_valid_q;
    mem_req_addr_d  = mem_req_addr_q;
    out_valid_d     = out_valid_q;
    out_block_d     = out_block_q;
    out_pix_d       = out_pix_q;
    out_uixt_d      = out_uixt_q;

    if (bus.flush) tag_valid_d = 1'b0;

    unique case (state_q)
      StIdle, StOut: begin
        if ((state_q == StOut) && bus.outReady) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
        if (accept) begin
          mem_req_addr_d = calc_addr;
          out_pix_d      = calc_pix;
          out_uixt_d     = bus.reqUIxt;
          miss_flushed_d = 1'b0;
          if (hit) begin
            out_block_d = data_q;
            out_valid_d = 1'b1;
            state_d     = StOut;
          end else begin
            mem_req_valid_d = 1'b1;
            state_d         = StMiss;
          end
        end
      end
      StMiss: begin
        if (bus.flush) miss_flushed_d = 1'b1;
        if (bus.memAck) begin
          tag_addr_d      = mem_req_addr_q;
          data_d          = bus.memData;
          // A flush seen at any point of the miss keeps this fill out of the cache.
          tag_valid_d     = !(bus.flush || miss_flushed_q);
          out_block_d     = bus.memData;
          out_valid_d     = 1'b1;
          mem_req_valid_d = 1'b0;
          state_d         = StOut;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q         <= StIdle;
      tag_valid_q     <= 1'b0;
      tag_addr_q      <= '0;
      data_q          <= '0;
      miss_flushed_q  <= 1'b0;
      mem_req_valid_q <= 1'b0;
      mem_req_addr_q  <= '0;
      out_valid_q     <= 1'b0;
      out_block_q     <= '0;
      out_pix_q       <= '0;
      out_uixt_q      <= '0;
    end else begin
      state_q         <= state_d;
      tag_valid_q     <= tag_valid_d;
      tag_addr_q      <= tag_addr_d;
      data_q          <= data_d;
      miss_flushed_q  <= miss_flushed_d;
      mem_req_valid_q <= mem_req_valid_d;
      mem_req_addr_q  <= mem_req_addr_d;
      out_valid_q     <= out_valid_d;
      out_block_q     <= out_block_d;
      out_pix_q       <= out_pix_d;
      out_uixt_q      <= out_uixt_d;
    end
  end

endmodule
